spi_mem_master_p: RTL
=====================

// Module: spi_mem_master_p
// PURPOSE
//  Parametrised SPI master for the SPI memory subsystem. It is the successor to the fixed 8-bit interface.
//  Accepts one read/write request per valid/ready handshake and serialises {din, addr, wr} LSB-first on mosi.
//  Completes writes on op_done, and deserialises read data from miso after the slave raises ready.
//  Sits between the UVM-driven request agent and the SPI memory slave.
// PARAMETERS
//  DATA_W          8     data width in bits (>=1)
//  ADDR_W          8     address width in bits (>=1)
//  MEM_DEPTH       32    valid address range is 0..MEM_DEPTH-1; MEM_DEPTH <= 2**ADDR_W
//  TIMEOUT_CYCLES  1024  max cycles in WAIT_DONE/WAIT_READY (used only with SPI_TIMEOUT_EN)
// PORTS
//  clk        in   1       clock, all logic on posedge
//  rst_n      in   1       synchronous active-low reset
//  req_valid  in   1       request present
//  req_ready  out  1       block can accept (high only in IDLE)
//  wr         in   1       1=write, 0=read; sampled on accept
//  addr       in   ADDR_W  target address; sampled on accept
//  din        in   DATA_W  write data; sampled on accept
//  dout       out  DATA_W  last read data; updated only on successful read
//  done       out  1       1-cycle completion pulse (success or error)
//  err        out  1       valid with done; 1 = request failed
//  err_code   out  2       valid with done: 0 ok, 1 address out of range, 2 timeout
//  busy       out  1       high from accept until the cycle after done
//  cs         out  1       chip select, active-low, idle high
//  mosi       out  1       serial data out, 0 when cs high
//  miso       in   1       serial data in
//  ready      in   1       slave read data available
//  op_done    in   1       slave write committed
// BEHAVIOUR
//  Reset (rst_n=0 at a posedge): state=IDLE, cs=1, mosi=0, done=0, err=0, err_code=0, dout=0, busy=0, counters=0.
//  Reset mid-transfer: the in-flight request is dropped with no done pulse; cs=1 after that edge.
//  States: IDLE, CHECK, SEND, WAIT_DONE, WAIT_READY, RECV, FINISH, ERROR.
//  IDLE: req_ready=1. On req_valid=1, latch frame={din,addr,wr} (wr = bit0) and the op, then go to CHECK.
//  CHECK (1 cycle): if addr>=MEM_DEPTH go to ERROR with cs held 1. Otherwise cs<=0, mosi<=frame[0], go to SEND.
//  SEND: cs is low for exactly N cycles, with mosi = frame[i] in the i-th low cycle.
//    N = 1+ADDR_W+DATA_W for a write; N = 1+ADDR_W for a read (din is not sent).
//    After the last bit: cs<=1, mosi<=0. Next state is WAIT_DONE (write) or WAIT_READY (read).
//  WAIT_DONE: on op_done=1 go to FINISH. op_done/ready seen in any other state are ignored.
//  WAIT_READY: on ready=1 go to RECV.
//  RECV: samples miso on DATA_W consecutive posedges starting with the edge after ready was seen.
//    Bit0 comes first. After the last bit, dout <= assembled word and the state goes to FINISH.
//  FINISH: done=1, err=0, err_code=0 for 1 cycle, then IDLE.
//  ERROR: done=1, err=1 and err_code as set for 1 cycle, then IDLE. dout is unchanged and cs never goes low.
//  req_valid while busy is ignored (no queue). Back-to-back: the next accept occurs at the earliest in the cycle after done.
//  Counters are sized $clog2(1+ADDR_W+DATA_W+1) and $clog2(TIMEOUT_CYCLES+1). No wrap-around is allowed.
//  Latency (write): accept edge E0; cs low from E1 through E1+N-1; done at the first edge after op_done is seen, +1.
// CONFIGURATION
//  SPI_TIMEOUT_EN defined: a wait counter is cleared on entry to WAIT_DONE/WAIT_READY.
//    If op_done/ready is still absent after TIMEOUT_CYCLES cycles in that state, go to ERROR with err_code=2.
//    A response arriving on the same cycle as expiry wins, and no error is raised.
//  SPI_TIMEOUT_EN undefined: no counter; the block waits indefinitely and err_code=2 never occurs.
// TESTING (DATA_W=8, ADDR_W=8, MEM_DEPTH=32)
//  Write addr=0x05 din=0xA5, op_done 3 cycles after cs rises -> 17 cs-low cycles, mosi=1,10100000,10100101;
//    done=1 err=0 err_code=0.
//  Read addr=0x1F; slave asserts ready, then drives 0x3C LSB-first -> 9 cs-low cycles, mosi=0,11111000;
//    dout=0x3C, done=1 err=0.
//  Write addr=0x20 -> cs stays 1 throughout; done=1 err=1 err_code=1 two cycles after accept; dout unchanged.
//  rst_n=0 during the 6th SEND bit -> next edge cs=1 mosi=0 busy=0, no done pulse.
//    A following write addr=0x00 din=0xFF then completes normally.
//  Read addr=0x02 with ready tied 0: with SPI_TIMEOUT_EN and TIMEOUT_CYCLES=16 -> done/err with err_code=2
//    16 cycles after WAIT_READY entry. Without the macro, busy stays 1 for 200 cycles.
//  req_valid held high across two writes -> second accept is exactly one cycle after the first done;
//    req_ready=0 throughout the first transfer.

Source files
------------

// File: rtl/spi_mem_master_p.sv
// SPI master for the SPI memory subsystem: serialises {din, addr, wr} LSB-first, then waits for
// op_done (write) or ready + DATA_W miso bits (read). Optional wait timeout: define SPI_TIMEOUT_EN.
module spi_mem_master_p #(
    parameter int DATA_W         = 8,
    parameter int ADDR_W         = 8,
    parameter int MEM_DEPTH      = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic              busy,
    output logic              cs,
    output logic              mosi,
    input  logic              miso,
    input  logic              ready,
    input  logic              op_done
);

    localparam int FRAME_W   = 1 + ADDR_W + DATA_W;
    localparam int BIT_CNT_W = $clog2(FRAME_W + 1);

    localparam logic [BIT_CNT_W-1:0] N_WR    = BIT_CNT_W'(FRAME_W);
    localparam logic [BIT_CNT_W-1:0] N_RD    = BIT_CNT_W'(1 + ADDR_W);
    localparam logic [BIT_CNT_W-1:0] RX_LAST = BIT_CNT_W'(DATA_W - 1);
    localparam logic [ADDR_W:0]      DEPTH_C = (ADDR_W + 1)'(MEM_DEPTH);

`ifdef SPI_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
`endif

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        SEND,
        WAIT_DONE,
        WAIT_READY,
        RECV,
        FINISH,
        ERROR
    } state_t;

    state_t                 state_q, state_d;
    logic [FRAME_W-1:0]     frame_q, frame_d;
    logic                   op_wr_q, op_wr_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]      rx_q, rx_d;
    logic [DATA_W-1:0]      dout_q, dout_d;
    logic                   cs_q, cs_d;
    logic                   mosi_q, mosi_d;
    logic [1:0]             err_code_q, err_code_d;
`ifdef SPI_TIMEOUT_EN
    logic [TO_W-1:0]        wait_cnt_q, wait_cnt_d;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            frame_q    <= '0;
            op_wr_q    <= 1'b0;
            bit_cnt_q  <= '0;
            rx_q       <= '0;
            dout_q     <= '0;
            cs_q       <= 1'b1;
            mosi_q     <= 1'b0;
            err_code_q <= 2'd0;
`ifdef SPI_TIMEOUT_EN
            wait_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            op_wr_q    <= op_wr_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_q       <= rx_d;
            dout_q     <= dout_d;
            cs_q       <= cs_d;
            mosi_q     <= mosi_d;
            err_code_q <= err_code_d;
`ifdef SPI_TIMEOUT_EN
            wait_cnt_q <= wait_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        op_wr_d    = op_wr_q;
        bit_cnt_d  = bit_cnt_q;
        rx_d       = rx_q;
        dout_d     = dout_q;
        cs_d       = cs_q;
        mosi_d     = mosi_q;
        err_code_d = err_code_q;
`ifdef SPI_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    frame_d    = {din, addr, wr};
                    op_wr_d    = wr;
                    err_code_d = 2'd0;
                    state_d    = CHECK;
                end
            end
            CHECK: begin
                if ({1'b0, frame_q[ADDR_W:1]} >= DEPTH_C) begin
                    err_code_d = 2'd1;
                    state_d    = ERROR;
                end else begin
                    // frame_q is a shift register: bit 0 is always the next bit to send
                    cs_d      = 1'b0;
                    mosi_d    = frame_q[0];
                    frame_d   = frame_q >> 1;
                    bit_cnt_d = BIT_CNT_W'(1);
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (bit_cnt_q == (op_wr_q ? N_WR : N_RD)) begin
                    cs_d      = 1'b1;
                    mosi_d    = 1'b0;
                    bit_cnt_d = '0;
`ifdef SPI_TIMEOUT_EN
                    wait_cnt_d = '0;
`endif
                    state_d   = op_wr_q ? WAIT_DONE : WAIT_READY;
                end else begin
                    mosi_d    = frame_q[0];
                    frame_d   = frame_q >> 1;
                    bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                end
            end
            WAIT_DONE: begin
                if (op_done) begin
                    state_d = FINISH;
                end
`ifdef SPI_TIMEOUT_EN
                else if (wait_cnt_q == TO_LAST) begin
                    err_code_d = 2'd2;
                    state_d    = ERROR;
                end else begin
                    wait_cnt_d = wait_cnt_q + TO_W'(1);
                end
`endif
            end
            WAIT_READY: begin
                if (ready) begin
                    bit_cnt_d = '0;
                    state_d   = RECV;
                end
`ifdef SPI_TIMEOUT_EN
                else if (wait_cnt_q == TO_LAST) begin
                    err_code_d = 2'd2;
                    state_d    = ERROR;
                end else begin
                    wait_cnt_d = wait_cnt_q + TO_W'(1);
                end
`endif
            end
            RECV: begin
                // Shift in from the top so the first (bit 0) sample ends up at the LSB
                rx_d = rx_q >> 1;
                rx_d[DATA_W-1] = miso;
                if (bit_cnt_q == RX_LAST) begin
                    dout_d    = rx_d;
                    bit_cnt_d = '0;
                    state_d   = FINISH;
                end else begin
                    bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                end
            end
            FINISH:  state_d = IDLE;
            ERROR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FINISH) || (state_q == ERROR);
    assign err       = (state_q == ERROR);
    assign err_code  = (state_q == ERROR) ? err_code_q : 2'd0;
    assign cs        = cs_q;
    assign mosi      = mosi_q;
    assign dout      = dout_q;

endmodule
